// File: rtl/mult_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mult_seq_ctrl
// Purpose  : Hardware sequencer for the signed 8x8 product. A falling edge on
//            start (seen while idle) reads operands A and B from data memory,
//            multiplies their magnitudes with an 8-iteration shift-add loop,
//            restores the sign, and writes the 16-bit two's-complement result
//            back little-endian before raising done.
// Ports    : clk          - single clock, rising edge
//            reset        - synchronous, active-high; forces IDLE
//            start        - request; a 1->0 transition launches one multiply
//            done         - high in DONE (acknowledge)
//            busy         - high in every state except IDLE and DONE
//            mem_addr     - data-memory address
//            mem_rd_data  - asynchronous read data for mem_addr
//            mem_wr_en    - write strobe (memory writes on rising edge)
//            mem_wr_data  - write data
// Revision : 1.0 - initial release
// ============================================================================
module mult_seq_ctrl #(
  parameter int AW           = 8,
  parameter int OPA_ADDR     = 0,
  parameter int OPB_ADDR     = 1,
  parameter int PROD_LO_ADDR = 2,
  parameter int PROD_HI_ADDR = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          done,
  output logic          busy,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rd_data,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wr_data
);

  localparam logic [2:0] c_idle  = 3'd0;
  localparam logic [2:0] c_ld_a  = 3'd1;
  localparam logic [2:0] c_ld_b  = 3'd2;
  localparam logic [2:0] c_mul   = 3'd3;
  localparam logic [2:0] c_fix   = 3'd4;
  localparam logic [2:0] c_wr_lo = 3'd5;
  localparam logic [2:0] c_wr_hi = 3'd6;
  localparam logic [2:0] c_done  = 3'd7;

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  logic        r_start_q;
  logic        w_launch;
  logic        r_sa;
  logic        r_sb;
  logic [15:0] r_mcand;   // |A|, shifted left one place per iteration
  logic [7:0]  r_mplier;  // |B|, shifted right so bit 0 is the current bit
  logic [15:0] r_acc;
  logic [2:0]  r_cnt;
  logic [7:0]  w_mag;

  // Start history has no reset so a start held low across reset release
  // cannot look like a falling edge.
  always_ff @(posedge clk) begin
    r_start_q <= start;
  end

  assign w_launch = r_start_q & ~start;

  // Magnitude of the byte currently on the read bus; -128 maps to 128,
  // which still fits in 8 unsigned bits.
  assign w_mag = mem_rd_data[7] ? (~mem_rd_data + 8'd1) : mem_rd_data;

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_idle:  if (w_launch) w_next = c_ld_a;
      c_ld_a:  w_next = c_ld_b;
      c_ld_b:  w_next = c_mul;
      c_mul:   if (r_cnt == 3'd0) w_next = c_fix;
      c_fix:   w_next = c_wr_lo;
      c_wr_lo: w_next = c_wr_hi;
      c_wr_hi: w_next = c_done;
      c_done:  if (start) w_next = c_idle;
      default: w_next = c_idle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= c_idle;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_mcand  <= 16'd0;
      r_mplier <= 8'd0;
      r_acc    <= 16'd0;
      r_cnt    <= 3'd0;
    end else begin
      r_state <= w_next;
      case (r_state)
        c_ld_a: begin
          r_sa    <= mem_rd_data[7];
          r_mcand <= {8'd0, w_mag};
        end
        c_ld_b: begin
          r_sb     <= mem_rd_data[7];
          r_mplier <= w_mag;
          r_acc    <= 16'd0;
          r_cnt    <= 3'd7;
        end
        c_mul: begin
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand  <= {r_mcand[14:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[7:1]};
          r_cnt    <= r_cnt - 3'd1;
        end
        c_fix: begin
          // Negate only a non-zero magnitude so 0 never becomes -0 noise.
          if ((r_sa != r_sb) && (r_acc != 16'd0)) r_acc <= ~r_acc + 16'd1;
        end
        default: ;
      endcase
    end
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    done        = (r_state == c_done);
    busy        = (r_state != c_idle) && (r_state != c_done);
    mem_addr    = '0;
    mem_wr_en   = 1'b0;
    mem_wr_data = 8'd0;
    case (r_state)
      c_ld_a:  mem_addr = OPA_ADDR[AW-1:0];
      c_ld_b:  mem_addr = OPB_ADDR[AW-1:0];
      c_wr_lo: begin
        mem_addr    = PROD_LO_ADDR[AW-1:0];
        mem_wr_en   = 1'b1;
        mem_wr_data = r_acc[7:0];
      end
      c_wr_hi: begin
        mem_addr    = PROD_HI_ADDR[AW-1:0];
        mem_wr_en   = 1'b1;
        mem_wr_data = r_acc[15:8];
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire
